// File: rtl/psum_acc.sv
// Partial-sum accumulation buffer: per-pixel signed accumulation with saturation,
// feeding a small valid/ready output FIFO under a credit-based input throttle.
module psum_acc #(
    parameter int DW_PSUM     = 24,
    parameter int DW_OFM      = 32,
    parameter int AW          = 6,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [AW-1:0]            in_addr,
    input  logic signed [DW_PSUM-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DW_OFM-1:0] out_data,
    output logic [AW-1:0]            out_addr,
    output logic                     ovf_sticky
);

    localparam int PW = $clog2(OFIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DW_OFM + 1;
    localparam logic [DW_OFM-1:0] SAT_MAX = {1'b0, {(DW_OFM-1){1'b1}}};
    localparam logic [DW_OFM-1:0] SAT_MIN = {1'b1, {(DW_OFM-1){1'b0}}};

    // Stage A registers
    logic                      va_q;
    logic                      a_first_q;
    logic                      a_last_q;
    logic [AW-1:0]             a_addr_q;
    logic [DW_PSUM-1:0]        a_data_q;

    logic [DW_OFM-1:0]         mem_q [2**AW];
    logic [DW_OFM-1:0]         rd_raw_q;
    logic [DW_OFM-1:0]         fwd_sum_q;
    logic                      fwd_q;

    logic [DW_OFM-1:0]         fifo_data_q [OFIFO_DEPTH];
    logic [AW-1:0]             fifo_addr_q [OFIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q, count_d;
    logic                      ovf_q;

    logic                      acc_w, push_w, pop_w, sat_d;
    logic [DW_OFM-1:0]         rd_w, sum_d;
    logic [SW-1:0]             wide_w;
    logic [CW:0]               credit_w;

    assign acc_w  = in_valid && in_ready;
    assign push_w = va_q && a_last_q;
    assign pop_w  = out_valid && out_ready;

    // Credits cover results already queued plus the beat still in the pipeline.
    assign credit_w = {1'b0, count_q} + (CW+1)'(va_q);
    assign in_ready = credit_w < (CW+1)'(OFIFO_DEPTH);

    always_comb begin
        rd_w   = fwd_q ? fwd_sum_q : rd_raw_q;
        wide_w = {rd_w[DW_OFM-1], rd_w} + {{(SW-DW_PSUM){a_data_q[DW_PSUM-1]}}, a_data_q};
        sat_d  = 1'b0;
        sum_d  = wide_w[DW_OFM-1:0];
        if (a_first_q) begin
            sum_d = {{(DW_OFM-DW_PSUM){a_data_q[DW_PSUM-1]}}, a_data_q};
        end else if (wide_w[SW-1] != wide_w[SW-2]) begin
            sat_d = 1'b1;
            sum_d = wide_w[SW-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Accumulation buffer: registered read, write-back from stage B.
    always_ff @(posedge clk) begin
        if (rst_n && va_q) begin
            mem_q[a_addr_q] <= sum_d;
        end
        rd_raw_q  <= mem_q[in_addr];
        fwd_sum_q <= sum_d;
    end

    always_ff @(posedge clk) begin
        if (acc_w) begin
            a_first_q <= in_first;
            a_last_q  <= in_last;
            a_addr_q  <= in_addr;
            a_data_q  <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            va_q     <= 1'b0;
            fwd_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            va_q    <= acc_w;
            // Stage B writes this address on the same edge the new read samples memory.
            fwd_q   <= va_q && (a_addr_q == in_addr);
            count_q <= count_d;
            if (push_w) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_w)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (va_q && sat_d) ovf_q <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OFIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (push_w && (wr_ptr_q == PW'(gi))) begin
                    fifo_data_q[gi] <= sum_d;
                    fifo_addr_q[gi] <= a_addr_q;
                end
            end
        end
    endgenerate

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_addr   = out_valid ? fifo_addr_q[rd_ptr_q] : '0;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_psum_acc.sv
// Directed bench for psum_acc: per-cycle comparison against a queue/array model
// plus literal expectations for each scenario.
module tb_psum_acc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, in_first, in_last;
    logic [5:0]         in_addr;
    logic [23:0]        in_data;
    logic               out_valid, out_ready;
    logic signed [31:0] out_data;
    logic [5:0]         out_addr;
    logic               ovf_sticky;

    psum_acc #(.DW_PSUM(24), .DW_OFM(32), .AW(6), .OFIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .in_addr(in_addr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     addr;
        longint cyc;
    } ent_t;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    ent_t   q[$];
    longint acc_m [64];
    bit     prev_nonlast = 0;
    bit     ovf_seen = 0;
    longint ovf_cyc = 0;
    longint got_d[$];
    int     got_a[$];

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: outputs are what the accumulation rules say, delivered two cycles after acceptance.
    always @(negedge clk) begin
        bit     exp_valid, exp_ready, exp_ovf;
        longint v, s;
        logic [31:0] ev;
        if (!rst_n) begin
            q.delete();
            prev_nonlast = 0;
            ovf_seen = 0;
        end else begin
            exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
            chk("out_valid", longint'(out_valid), longint'(exp_valid));
            if (exp_valid && out_valid) begin
                v  = q[0].val;
                ev = v[31:0];
                chk("out_data", longint'(out_data), longint'($signed(ev)));
                chk("out_addr", longint'(out_addr), longint'(q[0].addr));
            end
            exp_ready = (q.size() + int'(prev_nonlast)) < 4;
            chk("in_ready", longint'(in_ready), longint'(exp_ready));
            exp_ovf = ovf_seen && (cyc >= ovf_cyc + 2);
            chk("ovf_sticky", longint'(ovf_sticky), longint'(exp_ovf));
            if (exp_valid && out_ready) begin
                got_d.push_back(longint'(out_data));
                got_a.push_back(int'(out_addr));
                void'(q.pop_front());
            end
            prev_nonlast = 0;
            if (in_valid && in_ready) begin
                if (in_first) begin
                    s = longint'($signed(in_data));
                end else begin
                    s = acc_m[in_addr] + longint'($signed(in_data));
                    if (s > MAXV || s < MINV) begin
                        s = (s > MAXV) ? MAXV : MINV;
                        if (!ovf_seen) begin
                            ovf_seen = 1;
                            ovf_cyc  = cyc;
                        end
                    end
                end
                acc_m[in_addr] = s;
                if (in_last) q.push_back('{val: s, addr: int'(in_addr), cyc: cyc});
                else prev_nonlast = 1;
            end
        end
    end

    task automatic send(input bit f, input bit l, input int a, input int d);
        int n;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_addr  = a[5:0];
        in_data  = d[23:0];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (n >= 200) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_got(input string name, input int idx, input longint d, input int a);
        if (idx < got_d.size()) begin
            chk({name, "_data"}, got_d[idx], d);
            chk({name, "_addr"}, longint'(got_a[idx]), longint'(a));
        end else begin
            chk({name, "_missing"}, longint'(got_d.size()), longint'(idx + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_addr = '0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_addr", longint'(out_addr), 0);
        chk("rst_ovf", longint'(ovf_sticky), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        @(posedge clk); #1;

        // Basic accumulate and latency
        send(1, 0, 5, 100);
        send(0, 0, 5, -30);
        send(0, 1, 5, 7);
        @(negedge clk);
        chk("lat_t1_valid", longint'(out_valid), 0);
        @(negedge clk);
        chk("lat_t2_valid", longint'(out_valid), 1);
        drain();
        expect_got("basic", 0, 77, 5);
        got_d.delete(); got_a.delete();

        // Back-to-back forwarding, then interleaved addresses
        send(1, 0, 3, 1);
        send(0, 0, 3, 2);
        send(0, 0, 3, 3);
        send(0, 1, 3, 4);
        send(1, 0, 3, 10);
        send(1, 0, 4, 20);
        send(0, 1, 3, 5);
        send(0, 1, 4, 6);
        drain();
        expect_got("fwd", 0, 10, 3);
        expect_got("ilv3", 1, 15, 3);
        expect_got("ilv4", 2, 26, 4);
        got_d.delete(); got_a.delete();

        // Saturation, positive then negative
        send(1, 0, 0, 32'h7FFFFF);
        for (int i = 0; i < 258; i++) send(0, 0, 0, 32'h7FFFFF);
        send(0, 1, 0, 32'h7FFFFF);
        drain();
        expect_got("sat_pos", 0, MAXV, 0);
        chk("sat_ovf", longint'(ovf_sticky), 1);
        send(1, 0, 1, -8388608);
        for (int i = 0; i < 258; i++) send(0, 0, 1, -8388608);
        send(0, 1, 1, -8388608);
        drain();
        expect_got("sat_neg", 1, MINV, 1);
        got_d.delete(); got_a.delete();

        // Backpressure: six single-beat pixels with the consumer stalled
        out_ready = 1'b0;
        fork
            for (int i = 1; i <= 6; i++) send(1, 1, 10 + i, i);
            begin
                repeat (8) @(negedge clk);
                chk("bp_in_ready", longint'(in_ready), 0);
                chk("bp_head", longint'(out_data), 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        for (int i = 0; i < 6; i++) expect_got("bp_order", i, longint'(i + 1), 11 + i);
        got_d.delete(); got_a.delete();

        // Simultaneous push and pop with three entries held
        out_ready = 1'b0;
        send(1, 1, 20, 21);
        send(1, 1, 21, 22);
        send(1, 1, 22, 23);
        repeat (3) begin @(posedge clk); #1; end
        send(1, 1, 23, 24);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pp_in_ready", longint'(in_ready), 1);
        chk("pp_head", longint'(out_data), 22);
        @(posedge clk); #1;
        drain();
        for (int i = 0; i < 4; i++) expect_got("pp_order", i, longint'(21 + i), 20 + i);
        got_d.delete(); got_a.delete();

        // Reset with a partial accumulation in flight
        send(1, 0, 7, 1);
        send(0, 0, 7, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", longint'(out_valid), 0);
        chk("mrst_in_ready", longint'(in_ready), 1);
        chk("mrst_ovf", longint'(ovf_sticky), 0);
        chk("mrst_out_data", longint'(out_data), 0);
        @(posedge clk); #1;
        send(1, 1, 7, 9);
        drain();
        expect_got("mrst_fresh", 0, 9, 7);
        chk("mrst_count", longint'(got_d.size()), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
